// File: rtl/counter_bus_master.sv
// rtl/counter_bus_master.sv - host-side sequencer for a loadable counter on a shared bidirectional bus
//
// Accepts one command at a time (LOAD, READ, LOAD_VERIFY, RUN) and turns it
// into a timed sequence on the counter's en/load/oe pins and the shared data bus.
// It returns one response pulse per command. A dead cycle always separates
// host drive from counter drive.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; ready only in IDLE
//   cmd_op, cmd_data     opcode and load value / run length
//   rsp_valid            one-cycle response pulse
//   rsp_data, rsp_err    response value and verify-mismatch flag
//   cnt_en, cnt_load     counter count enable and load strobe
//   cnt_oe               counter drives the bus
//   bus_out, bus_oe      host drive value and per-bit drive enable
//   bus_in               bus value as seen by this block
module counter_bus_master #(
  parameter int DATA_W = 8,
  parameter int SETTLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              cnt_en,
  output logic              cnt_load,
  output logic              cnt_oe,
  output logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] bus_oe,
  input  logic [DATA_W-1:0] bus_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRIVE, S_LOAD, S_TURN1, S_READ, S_TURN2, S_RUN, S_DONE
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_READ = 2'd1;
  localparam logic [1:0] OP_LV   = 2'd2;
  localparam logic [1:0] OP_RUN  = 2'd3;

  // Read window lasts SETTLE+1 cycles; counter runs 0..SETTLE.
  localparam int RD_W = $clog2(SETTLE + 2);
  localparam logic [RD_W-1:0] RD_LAST = RD_W'(SETTLE);

  state_t            state, state_nx;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] run_q;
  logic [RD_W-1:0]   rd_q;
  logic              accept;
  logic              host_drive;

  assign cmd_ready = (state == S_IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_nx   = state;
    host_drive = 1'b0;
    cnt_en     = 1'b0;
    cnt_load   = 1'b0;
    cnt_oe     = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_LOAD, OP_LV: state_nx = S_DRIVE;
            OP_READ:        state_nx = S_READ;
            default:        state_nx = (cmd_data == '0) ? S_DONE : S_RUN;
          endcase
        end
      end
      S_DRIVE: begin
        host_drive = 1'b1;
        state_nx   = S_LOAD;
      end
      S_LOAD: begin
        host_drive = 1'b1;
        cnt_load   = 1'b1;
        state_nx   = S_TURN1;
      end
      S_TURN1: state_nx = (op_q == OP_LV) ? S_READ : S_DONE;
      S_READ: begin
        cnt_oe = 1'b1;
        if (rd_q == RD_LAST) state_nx = S_TURN2;
      end
      S_TURN2: state_nx = S_DONE;
      S_RUN: begin
        cnt_en = 1'b1;
        if (run_q == DATA_W'(1)) state_nx = S_DONE;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign bus_oe = {DATA_W{host_drive}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      op_q     <= OP_LOAD;
      data_q   <= '0;
      sample_q <= '0;
      run_q    <= '0;
      rd_q     <= '0;
      bus_out  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nx;

      if (accept) begin
        op_q   <= cmd_op;
        data_q <= cmd_data;
        run_q  <= cmd_data;
        // bus_out only follows load-type commands so it keeps the last load value.
        if (cmd_op == OP_LOAD || cmd_op == OP_LV) bus_out <= cmd_data;
      end

      if (state == S_RUN) run_q <= run_q - DATA_W'(1);

      if (state == S_READ) begin
        rd_q <= rd_q + RD_W'(1);
        if (rd_q == RD_LAST) sample_q <= bus_in;
      end else begin
        rd_q <= '0;
      end

      // Response registers change only on the edge into DONE and hold afterwards.
      if (state_nx == S_DONE && state != S_DONE) begin
        if (state == S_IDLE) begin
          // RUN with N=0 goes straight from IDLE; op_q is not yet valid here.
          rsp_data <= cmd_data;
          rsp_err  <= 1'b0;
        end else begin
          rsp_data <= (op_q == OP_READ || op_q == OP_LV) ? sample_q : data_q;
          rsp_err  <= (op_q == OP_LV) && (sample_q != data_q);
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_bus_master.sv
// tb/tb_counter_bus_master.sv - scoreboard bench for counter_bus_master with an attached counter model
module tb_counter_bus_master;

  localparam int SETTLE = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'd0;
  logic [7:0] cmd_data = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       cnt_en, cnt_load, cnt_oe;
  logic [7:0] bus_out, bus_oe, bus_in;

  counter_bus_master #(.DATA_W(8), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cnt_en(cnt_en), .cnt_load(cnt_load), .cnt_oe(cnt_oe),
    .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in)
  );

  always #5 clk = ~clk;

  // Counter model: no reset, captures the host drive on load, drives q when enabled.
  logic [7:0] q = 8'd0;
  logic [7:0] stuck = 8'd0;
  logic [7:0] host_bus;
  assign host_bus = (bus_oe != 8'd0) ? bus_out : 8'd0;
  assign bus_in   = cnt_oe ? (q | stuck) : host_bus;

  always @(posedge clk) begin
    if (cnt_load)    q <= host_bus;
    else if (cnt_en) q <= q + 8'd1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  typedef struct {
    int data;
    int err;
    int cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_acc = 0;
  int         n_rsp = 0;
  int         en_total = 0;
  logic [7:0] ref_q = 8'd0;

  // Accept monitor: computes expected response from the op-level counter model.
  always @(posedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
    end else if (cmd_valid && cmd_ready) begin
      case (cmd_op)
        2'd0: begin ref_q = cmd_data; e.data = cmd_data; e.err = 0; e.cyc = cyc + 4; end
        2'd1: begin e.data = ref_q | stuck; e.err = 0; e.cyc = cyc + SETTLE + 3; end
        2'd2: begin
          ref_q  = cmd_data;
          e.data = cmd_data | stuck;
          e.err  = ((cmd_data | stuck) != cmd_data) ? 1 : 0;
          e.cyc  = cyc + SETTLE + 6;
        end
        default: begin ref_q = ref_q + cmd_data; e.data = cmd_data; e.err = 0; e.cyc = cyc + cmd_data + 1; end
      endcase
      sb.push_back(e);
      n_acc++;
    end
    cyc++;
  end

  // Output monitor: responses, enable count, bus ownership.
  logic prev_host = 1'b0;
  logic prev_cnt  = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      n_rsp++;
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end
    if (cnt_en) en_total++;
    assert (!(bus_oe != 8'd0 && cnt_oe)) else chk("bus_contention", 1, 0);
    if ((bus_oe != 8'd0 && prev_cnt) || (cnt_oe && prev_host)) chk("bus_turnaround", 1, 0);
    if (bus_oe != 8'd0 && bus_oe != 8'hFF) chk("bus_oe_uniform", bus_oe, 8'hFF);
    prev_host = (bus_oe != 8'd0);
    prev_cnt  = cnt_oe;
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int  n = 0;
    bit  done = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
      if (cmd_ready && sb.size() == 0) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_bus_oe"}, bus_oe, 0);
    chk({tag, "_bus_out"}, bus_out, 0);
    chk({tag, "_pins"}, {cnt_en, cnt_load, cnt_oe}, 0);
  endtask

  initial begin
    int e0, a0, r0;
    // Reset with a command presented: it must not be accepted.
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd0; cmd_data = 8'h55;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    cmd_valid = 1'b0; rst = 1'b0;
    @(negedge clk);
    chk_quiet("post_reset");

    // LOAD 0xA5 with per-cycle pin checks.
    issue(2'd0, 8'hA5);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("load_c%0d_bus_oe", k), bus_oe, (k <= 2) ? 8'hFF : 8'h00);
      chk($sformatf("load_c%0d_bus_out", k), bus_out, 8'hA5);
      chk($sformatf("load_c%0d_cnt_load", k), cnt_load, (k == 2) ? 1 : 0);
      chk($sformatf("load_c%0d_ready", k), cmd_ready, 0);
      chk($sformatf("load_c%0d_rsp_valid", k), rsp_valid, (k == 4) ? 1 : 0);
    end
    wait_idle();

    // LOAD then READ through the counter model.
    issue(2'd0, 8'h3C); wait_idle();
    issue(2'd1, 8'h00); wait_idle();

    // LOAD_VERIFY with bit0 stuck high.
    stuck = 8'h01;
    issue(2'd2, 8'h5A); wait_idle();
    stuck = 8'h00;

    // Wrap through RUN, then a zero-length RUN.
    issue(2'd0, 8'hFE); wait_idle();
    e0 = en_total;
    issue(2'd3, 8'd3); wait_idle();
    chk("run3_en_cycles", en_total - e0, 3);
    issue(2'd1, 8'h00); wait_idle();
    e0 = en_total;
    issue(2'd3, 8'd0); wait_idle();
    chk("run0_en_cycles", en_total - e0, 0);

    // Reset during the LOAD cycle of LOAD_VERIFY; counter still captures.
    issue(2'd2, 8'h77);
    @(negedge clk);
    @(negedge clk);
    chk("abort_in_load", cnt_load, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_quiet("abort");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    issue(2'd1, 8'h00); wait_idle();

    // Continuous valid with ops and data changing every cycle.
    a0 = n_acc; r0 = n_rsp;
    cmd_valid = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cmd_op   = 2'($urandom_range(0, 3));
      cmd_data = (cmd_op == 2'd3) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
    end
    cmd_valid = 1'b0;
    wait_idle();
    chk("rsp_per_accept", n_rsp - r0, n_acc - a0);
    chk("random_accepts", (n_acc - a0) >= 20, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
